// File: rtl/fp_norm_arbiter.sv
// fp_norm_arbiter: two requesters share one 32-bit leading-zero counter and one
// left shifter. Each accepted request goes through IDLE -> CNT -> NORM -> OUT and
// comes back to IDLE, so a result is produced at most once every four cycles.
// The shared mantissa is shifted until its leading 1 sits at bit 31. The exponent
// is reduced by the same shift amount and clamped at zero for subnormal results.

// Combinational leading-zero count of a 32-bit word. nlz is 0 when the word is zero,
// so all_zero must be used to qualify the count.
module lzc_32bit (
  input  logic [31:0] data,
  output logic [4:0]  nlz,
  output logic        all_zero
);

  // Scan from LSB to MSB so the highest set bit writes last and wins.
  always_comb begin
    nlz      = '0;
    all_zero = (data == 32'd0);
    for (int i = 0; i < 32; i++) begin
      if (data[i]) nlz = 5'(31 - i);
    end
  end

endmodule

module fp_norm_arbiter #(
  parameter int EXP_W = 8,
  parameter bit RR_EN = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [1:0]       i_req_valid,
  output logic [1:0]       o_req_ready,
  input  logic [31:0]      i_req0_data,
  input  logic [EXP_W-1:0] i_req0_exp,
  input  logic             i_req0_sign,
  input  logic [31:0]      i_req1_data,
  input  logic [EXP_W-1:0] i_req1_exp,
  input  logic             i_req1_sign,
  output logic             o_valid,
  input  logic             i_out_ready,
  output logic [31:0]      o_data,
  output logic [EXP_W-1:0] o_exp,
  output logic             o_sign,
  output logic             o_zero,
  output logic             o_uf,
  output logic             o_id,
  output logic             o_busy
);

  typedef enum logic [1:0] {IDLE, CNT, NORM, OUT} state_t;

  typedef struct packed {
    logic [31:0]      data;
    logic [EXP_W-1:0] exp;
    logic             sign;
    logic             id;
  } req_t;

  state_t           state, state_nxt;
  req_t             cap;
  logic             last_id;
  logic [1:0]       grant;
  logic             hs;
  logic [4:0]       lz_cnt, nlz_q;
  logic             lz_zero, zero_q;
  logic [EXP_W-1:0] n_ext, uf_shift;
  logic [31:0]      r_data;
  logic [EXP_W-1:0] r_exp;
  logic             r_uf;

  // Grant: a lone valid requester wins outright; on contention the requester not
  // served last wins under round-robin, requester 0 always wins otherwise.
  always_comb begin
    grant = '0;
    case (i_req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (RR_EN && !last_id) ? 2'b10 : 2'b01;
      default: grant = '0;
    endcase
  end

  // Next state and ready. Ready is only offered in IDLE and is forced low while reset
  // is asserted, so every output reads 0 during reset.
  always_comb begin
    state_nxt   = state;
    o_req_ready = '0;
    case (state)
      IDLE: begin
        if (i_rst_n) o_req_ready = grant;
        if (|(grant & i_req_valid)) state_nxt = CNT;
      end
      CNT:     state_nxt = NORM;
      NORM:    state_nxt = OUT;
      OUT:     if (i_out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign hs     = |(o_req_ready & i_req_valid);
  assign o_busy = (state != IDLE);

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Capture the granted request. The pointer starts at 1 so requester 0 wins the
  // first contention after reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cap     <= '0;
      last_id <= 1'b1;
    end else if (state == IDLE && hs) begin
      cap     <= grant[1] ? req_t'{i_req1_data, i_req1_exp, i_req1_sign, 1'b1}
                          : req_t'{i_req0_data, i_req0_exp, i_req0_sign, 1'b0};
      last_id <= grant[1];
    end
  end

  lzc_32bit u_lzc (
    .data     (cap.data),
    .nlz      (lz_cnt),
    .all_zero (lz_zero)
  );

  // Register the count in CNT so the shifter in NORM starts from a flop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      nlz_q  <= '0;
      zero_q <= 1'b0;
    end else if (state == CNT) begin
      nlz_q  <= lz_cnt;
      zero_q <= lz_zero;
    end
  end

  assign n_ext    = EXP_W'(nlz_q);
  assign uf_shift = (cap.exp == '0) ? '0 : cap.exp - EXP_W'(1);

  // Result: a full normalization when the exponent can absorb the shift. Otherwise
  // the shift stops where the exponent reaches 0 and the result is flagged subnormal.
  always_comb begin
    r_data = '0;
    r_exp  = '0;
    r_uf   = 1'b0;
    if (!zero_q) begin
      if (cap.exp > n_ext) begin
        r_data = cap.data << nlz_q;
        r_exp  = cap.exp - n_ext;
      end else begin
        r_data = cap.data << uf_shift;
        r_uf   = 1'b1;
      end
    end
  end

  // Output register: loaded in NORM, held through OUT, valid cleared on consume.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_exp   <= '0;
      o_sign  <= 1'b0;
      o_zero  <= 1'b0;
      o_uf    <= 1'b0;
      o_id    <= 1'b0;
    end else if (state == NORM) begin
      o_valid <= 1'b1;
      o_data  <= r_data;
      o_exp   <= r_exp;
      o_sign  <= cap.sign;
      o_zero  <= zero_q;
      o_uf    <= r_uf;
      o_id    <= cap.id;
    end else if (state == OUT && i_out_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fp_norm_arbiter.sv
// Bench for fp_norm_arbiter: directed and random requests checked against an
// arithmetic reference model. Two instances cover round-robin and fixed priority.
module tb_fp_norm_arbiter;

  typedef struct {
    logic [31:0] data;
    logic [7:0]  exp;
    logic        zero;
    logic        uf;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, b_req_valid;
  logic [31:0] d0, d1;
  logic [7:0]  e0, e1;
  logic        s0, s1;
  logic        a_out_ready, b_out_ready;

  logic [1:0]  a_ready, b_ready;
  logic        a_valid, b_valid;
  logic [31:0] a_data, b_data;
  logic [7:0]  a_exp, b_exp;
  logic        a_sign, b_sign, a_zero, b_zero, a_uf, b_uf, a_id, b_id, a_busy, b_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp_norm_arbiter #(.EXP_W(8), .RR_EN(1'b1)) dut_rr (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .o_req_ready(a_ready),
    .i_req0_data(d0), .i_req0_exp(e0), .i_req0_sign(s0),
    .i_req1_data(d1), .i_req1_exp(e1), .i_req1_sign(s1),
    .o_valid(a_valid), .i_out_ready(a_out_ready), .o_data(a_data), .o_exp(a_exp),
    .o_sign(a_sign), .o_zero(a_zero), .o_uf(a_uf), .o_id(a_id), .o_busy(a_busy)
  );

  fp_norm_arbiter #(.EXP_W(8), .RR_EN(1'b0)) dut_fp (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(b_req_valid), .o_req_ready(b_ready),
    .i_req0_data(d0), .i_req0_exp(e0), .i_req0_sign(s0),
    .i_req1_data(d1), .i_req1_exp(e1), .i_req1_sign(s1),
    .o_valid(b_valid), .i_out_ready(b_out_ready), .o_data(b_data), .o_exp(b_exp),
    .o_sign(b_sign), .o_zero(b_zero), .o_uf(b_uf), .o_id(b_id), .o_busy(b_busy)
  );

  // Reference: count leading zeros by walking down from bit 31, then apply the
  // exponent rules with plain integer arithmetic.
  function automatic res_t model(input logic [31:0] d, input logic [7:0] e);
    res_t r;
    int   n;
    int   s;
    r.data = '0; r.exp = '0; r.zero = 1'b0; r.uf = 1'b0;
    if (d == 32'd0) begin
      r.zero = 1'b1;
      return r;
    end
    n = 0;
    while (d[31 - n] == 1'b0) n++;
    if (int'(e) > n) begin
      r.data = d << n;
      r.exp  = 8'(int'(e) - n);
    end else begin
      s      = (e == 8'd0) ? 0 : int'(e) - 1;
      r.data = d << s;
      r.uf   = 1'b1;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0; b_req_valid = '0;
    a_out_ready = 1'b1; b_out_ready = 1'b1;
    d0 = '0; d1 = '0; e0 = '0; e1 = '0; s0 = 1'b0; s1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(a_valid), 64'd0);
    chk("rst_busy",  64'(a_busy),  64'd0);
    chk("rst_ready", 64'(a_ready), 64'd0);
    chk("rst_data",  64'(a_data),  64'd0);
    chk("rst_exp",   64'(a_exp),   64'd0);
    chk("rst_b_valid", 64'(b_valid), 64'd0);
    rst_n = 1'b1;
  endtask

  // One request on the round-robin instance, optionally held in OUT for `stall` cycles.
  task automatic run_req(input int id, input logic [31:0] d, input logic [7:0] e,
                         input logic s, input int stall);
    res_t m;
    int   edges;
    bit   got;
    m = model(d, e);
    a_out_ready = (stall == 0);
    if (id == 0) begin d0 = d; e0 = e; s0 = s; req_valid = 2'b01; end
    else         begin d1 = d; e1 = e; s1 = s; req_valid = 2'b10; end
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (a_ready[id[0]]) got = 1'b1;
      @(posedge clk);
      #1;
    end
    req_valid = 2'b00;
    chk("handshake", 64'(got), 64'd1);
    edges = 1;
    got   = 1'b0;
    while (edges < 10 && !got) begin
      @(negedge clk);
      if (a_valid) got = 1'b1;
      else begin
        @(posedge clk);
        #1;
        edges++;
      end
    end
    chk("latency_edges", 64'(edges), 64'd3);
    chk("data",  64'(a_data), 64'(m.data));
    chk("exp",   64'(a_exp),  64'(m.exp));
    chk("zero",  64'(a_zero), 64'(m.zero));
    chk("uf",    64'(a_uf),   64'(m.uf));
    chk("sign",  64'(a_sign), 64'(s));
    chk("id",    64'(a_id),   64'(id));
    chk("busy_in_out",  64'(a_busy),  64'd1);
    for (int k = 0; k < stall; k++) begin
      req_valid = 2'b11;
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("stall_valid", 64'(a_valid), 64'd1);
      chk("stall_data",  64'(a_data),  64'(m.data));
      chk("stall_exp",   64'(a_exp),   64'(m.exp));
      chk("stall_ready", 64'(a_ready), 64'd0);
    end
    req_valid   = 2'b00;
    a_out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("valid_cleared", 64'(a_valid), 64'd0);
    chk("idle_after_out", 64'(a_busy), 64'd0);
  endtask

  // Both requesters valid continuously; the served id sequence follows the policy.
  task automatic contend(input bit use_b, input int n_served);
    int   served;
    logic last;
    logic exp_id;
    logic [1:0] rdy;
    logic vld, bsy, rid;
    logic [31:0] rdat;
    res_t m;
    served = 0;
    last   = 1'b1;
    d0 = 32'h0000_0100; e0 = 8'd60; s0 = 1'b0;
    d1 = 32'h0040_0000; e1 = 8'd20; s1 = 1'b1;
    if (use_b) b_req_valid = 2'b11; else req_valid = 2'b11;
    for (int c = 0; c < 80 && served < n_served; c++) begin
      @(negedge clk);
      rdy  = use_b ? b_ready : a_ready;
      vld  = use_b ? b_valid : a_valid;
      bsy  = use_b ? b_busy  : a_busy;
      rid  = use_b ? b_id    : a_id;
      rdat = use_b ? b_data  : a_data;
      if (bsy) chk("ready_while_busy", 64'(rdy), 64'd0);
      if (vld) begin
        exp_id = (!use_b && !last) ? 1'b1 : 1'b0;
        m = model(exp_id ? d1 : d0, exp_id ? e1 : e0);
        chk("served_id", 64'(rid), 64'(exp_id));
        chk("served_data", 64'(rdat), 64'(m.data));
        last = exp_id;
        served++;
      end
      @(posedge clk);
      #1;
    end
    chk("served_count", 64'(served), 64'(n_served));
    req_valid = 2'b00;
    b_req_valid = 2'b00;
  endtask

  initial begin
    int          id;
    logic [31:0] d;
    logic [7:0]  e;

    rst_n = 1'b0;
    do_reset();

    // Directed cases from the datasheet plus exponent boundaries.
    run_req(0, 32'h0000_1000, 8'd100, 1'b0, 0);
    run_req(1, 32'h0000_0001, 8'd10,  1'b0, 0);
    run_req(0, 32'h0000_0000, 8'd50,  1'b1, 0);
    run_req(1, 32'h0000_8000, 8'd16,  1'b0, 0);
    run_req(0, 32'h0000_8000, 8'd17,  1'b1, 0);
    run_req(1, 32'h0000_0001, 8'd0,   1'b0, 0);
    run_req(0, 32'h8000_0001, 8'd0,   1'b0, 0);

    // Consumer stall in OUT.
    run_req(0, 32'h00FF_0000, 8'd200, 1'b1, 5);

    // Reset while in NORM discards the transaction.
    a_out_ready = 1'b1;
    d0 = 32'h0000_0F00; e0 = 8'd90; s0 = 1'b1;
    req_valid = 2'b01;
    @(negedge clk);
    chk("pre_rst_ready", 64'(a_ready), 64'd1);
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    chk("pre_rst_busy", 64'(a_busy), 64'd1);
    @(posedge clk);
    #1;
    req_valid = 2'b01;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(a_valid), 64'd0);
    chk("mid_rst_busy",  64'(a_busy),  64'd0);
    chk("mid_rst_ready", 64'(a_ready), 64'd0);
    chk("mid_rst_data",  64'(a_data),  64'd0);
    chk("mid_rst_exp",   64'(a_exp),   64'd0);
    chk("mid_rst_sign",  64'(a_sign),  64'd0);
    chk("mid_rst_uf",    64'(a_uf),    64'd0);
    req_valid = 2'b00;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("post_rst_no_valid", 64'(a_valid), 64'd0);
    end
    run_req(1, 32'h0000_0F00, 8'd90, 1'b0, 0);

    // Random requests from one requester at a time.
    for (int i = 0; i < 30; i++) begin
      id = int'($urandom_range(0, 1));
      d  = $urandom >> $urandom_range(0, 32);
      e  = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom_range(0, 255));
      run_req(id, d, e, 1'($urandom_range(0, 1)), 0);
    end

    // Contention: round-robin alternates, fixed priority always serves requester 0.
    do_reset();
    contend(1'b0, 4);
    do_reset();
    contend(1'b1, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
